// File: rtl/mc_pkg.sv
// ----------------------------------------------------------------------------
// mc_pkg
// Shared types and constants for the multi-cycle RV32I control unit.
//   alu_op_t   : 4-bit ALU operation codes driven on the operation port
//   state_t    : control FSM state encoding
//   opc_*      : RV32I major opcodes recognised by the controller
//   srca_*     : ALU A-operand mux selects
//   srcb_*     : ALU B-operand mux selects
//   res_*      : result-bus mux selects
//   decode_target() : state entered after DECODE for a given opcode
// ----------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SLL = 4'b0001,
    OP_SLT = 4'b0010,
    OP_XOR = 4'b0100,
    OP_SRL = 4'b0101,
    OP_OR  = 4'b0110,
    OP_AND = 4'b0111,
    OP_SUB = 4'b1000,
    OP_BNE = 4'b1001,
    OP_BLT = 4'b1010,
    OP_BGE = 4'b1011
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALPC    = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;

  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  // Dispatch from DECODE; anything unrecognised goes to TRAP.
  function automatic state_t decode_target(input logic [6:0] opc);
    state_t s;
    case (opc)
      OPC_LOAD,
      OPC_STORE:  s = S_MEMADR;
      OPC_OP:     s = S_EXECR;
      OPC_OPIMM:  s = S_EXECI;
      OPC_BRANCH: s = S_BRANCH;
      OPC_JAL:    s = S_JAL;
      OPC_LUI:    s = S_LUI;
      default:    s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ----------------------------------------------------------------------------
// mc_alu_decoder
// Purely combinational ALU operation decoder.
//   opcode    in  7  instruction major opcode
//   funct3    in  3  instruction funct3 field
//   funct7    in  7  instruction funct7 field
//   operation out 4  ALU operation for EXECR / EXECI / BRANCH
//   illegal   out 1  opcode/funct combination not supported by this core
// Opcodes that only need address/target arithmetic (load, store, jal, lui)
// decode to ADD and are never illegal here.
// ----------------------------------------------------------------------------
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_t    operation,
  output logic       illegal
);

  // R-type accepts funct7 = 0 for every op and 0100000 only for SUB (no SRA).
  // I-type ignores funct7 except on shifts, where SRAI is rejected.
  always_comb begin
    operation = OP_ADD;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) operation = OP_SUB;
          else                  illegal   = 1'b1;
        end else if (funct7 != 7'b0000000) begin
          illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000:  operation = OP_ADD;
            3'b001:  operation = OP_SLL;
            3'b010:  operation = OP_SLT;
            3'b100:  operation = OP_XOR;
            3'b101:  operation = OP_SRL;
            3'b110:  operation = OP_OR;
            3'b111:  operation = OP_AND;
            default: illegal   = 1'b1;
          endcase
        end
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b000: operation = OP_ADD;
          3'b001: begin
            operation = OP_SLL;
            illegal   = (funct7 != 7'b0000000);
          end
          3'b010: operation = OP_SLT;
          3'b100: operation = OP_XOR;
          3'b101: begin
            operation = OP_SRL;
            illegal   = (funct7 != 7'b0000000);
          end
          3'b110:  operation = OP_OR;
          3'b111:  operation = OP_AND;
          default: illegal   = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  operation = OP_SUB;
          3'b001:  operation = OP_BNE;
          3'b100:  operation = OP_BLT;
          3'b101:  operation = OP_BGE;
          default: illegal   = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_LUI: operation = OP_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multi-cycle RV32I datapath: sequences
// fetch / decode / execute / memory / writeback and drives mux selects,
// write strobes, the ALU operation code and the memory handshake.
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   instr       in  32  instruction register contents (valid from DECODE)
//   zero        in   1  ALU zero flag, 1 = branch condition true
//   mem_ready   in   1  memory completes the current access this cycle
//   mem_req     out  1  memory access request, held until mem_ready
//   mem_write   out  1  qualifies mem_req as a store
//   adr_src     out  1  0 = PC, 1 = ALU_OUT register as memory address
//   ir_write    out  1  load INSTR / OLD_PC registers
//   pc_write    out  1  load PC from result bus
//   reg_write   out  1  register-file write enable
//   alu_src_a   out  2  0 = PC, 1 = OLD_PC, 2 = rs1, 3 = zero
//   alu_src_b   out  2  0 = rs2, 1 = immediate, 2 = constant 4
//   result_src  out  2  0 = ALU_OUT reg, 1 = MEM_DATA reg, 2 = ALU result
//   operation   out  4  ALU operation code
//   illegal     out  1  sticky: unsupported instruction decoded
//   instret     out XLEN retired-instruction count (only with MC_INSTRET_EN)
// Optional feature macro: MC_INSTRET_EN adds the instret port and counter.
// ----------------------------------------------------------------------------
module multicycle_control
  import mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [3:0]  operation,
  output logic        illegal
`ifdef MC_INSTRET_EN
  ,
  output logic [XLEN-1:0] instret
`endif
);

  state_t     state;
  state_t     next_state;
  alu_op_t    dec_op;
  logic       dec_illegal;
  logic [6:0] opcode;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  mc_alu_decoder u_alu_decoder (
    .opcode    (opcode),
    .funct3    (instr[14:12]),
    .funct7    (instr[31:25]),
    .operation (dec_op),
    .illegal   (dec_illegal)
  );

  // State register; reset aborts whatever is in flight and restarts at FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Next-state logic. Illegal funct combinations are caught in DECODE so no
  // write strobe is ever issued for an unsupported instruction.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE:   next_state = dec_illegal ? S_TRAP : decode_target(opcode);
      S_MEMADR:   next_state = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXECR,
      S_EXECI:    next_state = dec_illegal ? S_TRAP : S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JAL:      next_state = S_JALPC;
      S_JALPC:    next_state = S_FETCH;
      S_LUI:      next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  // Output decode. Everything is forced to zero while rst_n is low so a
  // reset in the middle of an access drops the request in the same cycle.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    operation  = OP_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        operation = dec_op;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        operation = dec_op;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      // ALU_OUT still holds the target computed in DECODE.
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        operation  = dec_op;
        result_src = RES_ALUOUT;
        pc_write   = zero;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
      end
      S_JALPC: begin
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      // Zero on the A input makes the ALU pass the U-immediate straight through.
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        reg_write  = 1'b1;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'd0;
      alu_src_b  = 2'd0;
      result_src = 2'd0;
      operation  = 4'd0;
      illegal    = 1'b0;
    end
  end

`ifdef MC_INSTRET_EN
  logic retire;

  // An instruction retires on the last cycle of its sequence.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_JALPC, S_LUI: retire = 1'b1;
      S_MEMWRITE: retire = mem_ready;
      default:    retire = 1'b0;
    endcase
  end

  // Free-running retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + XLEN'(1);
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
// Directed-vector bench. Each applyStimulus call drives one cycle of inputs
// and queues the control word expected for that cycle; an independent
// monitor pops and compares on every falling edge.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  operation;
  logic        illegal;
`ifdef MC_INSTRET_EN
  logic [31:0] instret;
`endif

  multicycle_control #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .operation  (operation),
    .illegal    (illegal)
`ifdef MC_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  always #5 clk = ~clk;

  // Control word: req, wr, adr, ir, pc, rw, a, b, res, op, illegal.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] res;
    logic [3:0] op;
    logic       ill;
  } ctl_t;

  function automatic ctl_t mk(input logic rq, input logic wr, input logic ad,
                              input logic ir, input logic pc, input logic rw,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] rs, input logic [3:0] op,
                              input logic il);
    ctl_t c;
    c = {rq, wr, ad, ir, pc, rw, a, b, rs, op, il};
    return c;
  endfunction

  ctl_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;
  logic        rst_val;
  logic [31:0] ins_val;
  ctl_t  actual;

  always_comb actual = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                        alu_src_a, alu_src_b, result_src, operation, illegal};

  task automatic checkOutput(input string n, input ctl_t act, input ctl_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %05h expected %05h", n, act, exp);
    end
  endtask

  task automatic checkCount(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic applyStimulus(input string n, input logic rdy, input logic z, input ctl_t e);
    @(posedge clk);
    #1;
    rst_n     = rst_val;
    mem_ready = rdy;
    zero      = z;
    instr     = ins_val;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Monitor: compares the queued expectation against the live outputs.
  always @(negedge clk) begin : monitor
    ctl_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(n, actual, e);
    end
  end

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BGE  = 32'h0020D463;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_SRAI = 32'h4010D093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  ctl_t e_rst, e_fw, e_fr, e_dec, e_awb, e_ma, e_mw, e_mr, e_mwb, e_jal, e_jpc, e_lui, e_trap;

  task automatic fetchDecode(input logic [31:0] ins);
    ins_val = ins;
    applyStimulus("fetch_ready", 1'b1, 1'b0, e_fr);
    applyStimulus("decode", 1'b0, 1'b0, e_dec);
  endtask

  initial begin
    e_rst  = mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 4'b0000, 0);
    e_fw   = mk(1,0,0,0,0,0, 2'd0,2'd2,2'd2, 4'b0000, 0);
    e_fr   = mk(1,0,0,1,1,0, 2'd0,2'd2,2'd2, 4'b0000, 0);
    e_dec  = mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 4'b0000, 0);
    e_awb  = mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 4'b0000, 0);
    e_ma   = mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 4'b0000, 0);
    e_mw   = mk(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 4'b0000, 0);
    e_mr   = mk(1,0,1,0,0,0, 2'd0,2'd0,2'd0, 4'b0000, 0);
    e_mwb  = mk(0,0,0,0,0,1, 2'd0,2'd0,2'd1, 4'b0000, 0);
    e_jal  = mk(0,0,0,0,0,1, 2'd1,2'd2,2'd2, 4'b0000, 0);
    e_jpc  = mk(0,0,0,0,1,0, 2'd0,2'd0,2'd0, 4'b0000, 0);
    e_lui  = mk(0,0,0,0,0,1, 2'd3,2'd1,2'd2, 4'b0000, 0);
    e_trap = mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 4'b0000, 1);

    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; instr = '0;
    rst_val = 1'b0; ins_val = '0;

    applyStimulus("reset0", 1'b0, 1'b0, e_rst);
    applyStimulus("reset1", 1'b1, 1'b1, e_rst);

    // Release with memory stalled for three cycles.
    rst_val = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("fetch_wait", 1'b0, 1'b0, e_fw);

    fetchDecode(I_ADD);
    applyStimulus("execr_add", 1'b0, 1'b0, mk(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 4'b0000, 0));
    applyStimulus("aluwb_add", 1'b0, 1'b0, e_awb);

    fetchDecode(I_SUB);
    applyStimulus("execr_sub", 1'b0, 1'b0, mk(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 4'b1000, 0));
    applyStimulus("aluwb_sub", 1'b0, 1'b0, e_awb);

    fetchDecode(I_BEQ);
    applyStimulus("branch_beq_taken", 1'b0, 1'b1, mk(0,0,0,0,1,0, 2'd2,2'd0,2'd0, 4'b1000, 0));

    fetchDecode(I_BGE);
    applyStimulus("branch_bge_not", 1'b0, 1'b0, mk(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 4'b1011, 0));

    fetchDecode(I_ADDI);
    applyStimulus("execi_addi", 1'b0, 1'b0, mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 4'b0000, 0));
    applyStimulus("aluwb_addi", 1'b0, 1'b0, e_awb);

    fetchDecode(I_LW);
    applyStimulus("memadr_lw", 1'b0, 1'b0, e_ma);
    applyStimulus("memread_wait", 1'b0, 1'b0, e_mr);
    applyStimulus("memread_ready", 1'b1, 1'b0, e_mr);
    applyStimulus("memwb", 1'b0, 1'b0, e_mwb);

    fetchDecode(I_SW);
    applyStimulus("memadr_sw", 1'b0, 1'b0, e_ma);
    applyStimulus("memwrite_wait0", 1'b0, 1'b0, e_mw);
    applyStimulus("memwrite_wait1", 1'b0, 1'b0, e_mw);
    applyStimulus("memwrite_ready", 1'b1, 1'b0, e_mw);

    fetchDecode(I_LUI);
    applyStimulus("lui", 1'b0, 1'b0, e_lui);

    fetchDecode(I_JAL);
    applyStimulus("jal", 1'b0, 1'b0, e_jal);
    applyStimulus("jalpc", 1'b0, 1'b0, e_jpc);

    // Reset pulse in the middle of a store.
    fetchDecode(I_SW);
    applyStimulus("memadr_sw2", 1'b0, 1'b0, e_ma);
    applyStimulus("memwrite_pre_abort", 1'b0, 1'b0, e_mw);
`ifdef MC_INSTRET_EN
    checkCount("instret_before_abort", instret, 32'd9);
`endif
    rst_val = 1'b0;
    applyStimulus("memwrite_abort", 1'b0, 1'b0, e_rst);
`ifdef MC_INSTRET_EN
    #1 checkCount("instret_after_abort", instret, 32'd0);
`endif
    rst_val = 1'b1;
    applyStimulus("fetch_after_abort", 1'b0, 1'b0, e_fw);

    // SRAI is not supported and must trap without any write strobe.
    fetchDecode(I_SRAI);
    applyStimulus("trap_srai0", 1'b0, 1'b0, e_trap);
    applyStimulus("trap_srai1", 1'b1, 1'b1, e_trap);
    rst_val = 1'b0;
    applyStimulus("reset_srai", 1'b0, 1'b0, e_rst);
    rst_val = 1'b1;
    applyStimulus("fetch_after_srai", 1'b0, 1'b0, e_fw);

    // Unknown opcode: sticky trap for ten cycles regardless of inputs.
    fetchDecode(I_BAD);
    for (int i = 0; i < 10; i++)
      applyStimulus("trap_bad_opcode", i[0], ~i[0], e_trap);
    rst_val = 1'b0;
    applyStimulus("reset_clears_illegal", 1'b0, 1'b0, e_rst);
    rst_val = 1'b1;
    applyStimulus("fetch_after_trap", 1'b0, 1'b0, e_fw);

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
